multi_project_io_mux: RTL and testbench

- Parametrised successor to the single-design user-area wrapper. Shares the GPIO pads and one 32-bit logic-analyser (LA) chunk among NUM_PROJ wrapped user designs.
- Selection comes from one-hot LA "active" bits. Every change of design runs a safe switch sequence: debounce, isolate pads, hold the new design in reset, then connect.
- Sits directly inside user_project_wrapper, between the pads/LA and the wrapped designs.

---
 rtl/multi_proj_pkg.sv | 27 ++
 rtl/mux_stable_detect.sv | 75 +++++++
 rtl/multi_project_io_mux.sv | 212 +++++++++++++++++++++
 tb/tb_multi_project_io_mux.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_proj_pkg.sv
// Shared definitions for the multi-project IO mux: the switch-sequence
// states, the "no design connected" select encoding and default widths.
package multi_proj_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RESET = 2'd2,
      RUN   = 2'd3
   } mux_state_t;

   localparam int DEFAULT_IO_W = 38;
   localparam int DEFAULT_LA_W = 32;

   // Widest select bus needed for up to 8 designs ($clog2(8)+1).
   localparam int SEL_W_MAX = 4;

   // NONE is encoded by setting the MSB of the select bus; the caller
   // truncates the result to its own select width.
   function automatic logic [SEL_W_MAX-1:0] sel_none_code(input int sel_w);
      logic [SEL_W_MAX-1:0] code;
      code = '0;
      code[sel_w-1] = 1'b1;
      return code;
   endfunction

endpackage

// File: rtl/mux_stable_detect.sv
// Debouncer for the one-hot design-select bits. A value is accepted once it
// has been seen unchanged for STABLE_CYCLES consecutive clock edges; the
// accept strobe fires once per stable value.
module mux_stable_detect
   import multi_proj_pkg::*;
#(
   parameter int NUM_PROJ      = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int SEL_W         = $clog2(NUM_PROJ) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_PROJ-1:0] active,
   output logic [SEL_W-1:0]    target,
   output logic                accept,
   output logic                multi_hot
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(sel_none_code(SEL_W));

   logic [NUM_PROJ-1:0] last_val;
   logic [CW-1:0]       stable_cnt;
   logic [CW-1:0]       stable_next;
   logic                changed;
   logic                found;

   assign changed = (active != last_val);

   // Count consecutive unchanged samples, restarting at one on any change and holding at the terminal value.
   always_comb begin
      if (changed) begin
         stable_next = CW'(1);
      end else if (stable_cnt == CW'(STABLE_CYCLES)) begin
         stable_next = stable_cnt;
      end else begin
         stable_next = stable_cnt + CW'(1);
      end
   end

   // Strobe only on the sample that first reaches the stable count, so a held value is accepted once.
   assign accept = (stable_next == CW'(STABLE_CYCLES)) &&
                   (changed || (stable_cnt != CW'(STABLE_CYCLES)));

   // Remember the previous sample and the length of the current run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_val   <= '0;
         stable_cnt <= '0;
      end else begin
         last_val   <= active;
         stable_cnt <= stable_next;
      end
   end

   // Decode the select bits: exactly one hot gives its index, none or several give NONE.
   always_comb begin
      target    = SEL_NONE;
      multi_hot = 1'b0;
      found     = 1'b0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         if (active[i]) begin
            if (found) begin
               multi_hot = 1'b1;
            end
            found  = 1'b1;
            target = SEL_W'(i);
         end
      end
      if (multi_hot) begin
         target = SEL_NONE;
      end
   end

endmodule

// File: rtl/multi_project_io_mux.sv
// Shares the GPIO pads and one LA chunk among NUM_PROJ wrapped designs.
// Every change of selection runs drain (pads isolated), reset (new design
// held in reset) and only then connects the new design.
// Optional macro PROJ_CLK_GATE_EN: when defined, only the design being reset
// or running gets its clock enable; otherwise all clock enables stay high.
module multi_project_io_mux
   import multi_proj_pkg::*;
#(
   parameter int NUM_PROJ      = 4,
   parameter int IO_W          = DEFAULT_IO_W,
   parameter int LA_W          = DEFAULT_LA_W,
   parameter int STABLE_CYCLES = 4,
   parameter int GUARD_CYCLES  = 16,
   parameter int RST_CYCLES    = 8
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_ni,
   input  logic [NUM_PROJ-1:0]       active_i,
   input  logic [IO_W-1:0]           io_in,
   output logic [IO_W-1:0]           io_out,
   output logic [IO_W-1:0]           io_oeb,
   input  logic [LA_W-1:0]           la_data_in,
   input  logic [LA_W-1:0]           la_oenb,
   output logic [LA_W-1:0]           la_data_out,
   output logic [NUM_PROJ*IO_W-1:0]  proj_io_in,
   input  logic [NUM_PROJ*IO_W-1:0]  proj_io_out,
   input  logic [NUM_PROJ*IO_W-1:0]  proj_io_oeb,
   output logic [NUM_PROJ*LA_W-1:0]  proj_la_in,
   output logic [NUM_PROJ*LA_W-1:0]  proj_la_oenb,
   input  logic [NUM_PROJ*LA_W-1:0]  proj_la_out,
   output logic [NUM_PROJ-1:0]       proj_rst_n,
   output logic [NUM_PROJ-1:0]       proj_clk_en,
   output logic [$clog2(NUM_PROJ):0] sel_o,
   output logic                      busy_o,
   output logic                      err_o
);

   localparam int SEL_W = $clog2(NUM_PROJ) + 1;
   localparam int IDX_W = SEL_W - 1;
   localparam int GW    = $clog2(GUARD_CYCLES + 1);
   localparam int RW    = $clog2(RST_CYCLES + 1);
   localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(sel_none_code(SEL_W));

   logic [SEL_W-1:0]    acc_target;
   logic                accept;
   logic                multi_hot;
   logic                new_sel;

   mux_state_t          state;
   logic [SEL_W-1:0]    cur_target;
   logic [GW-1:0]       guard_cnt;
   logic [GW-1:0]       guard_inc;
   logic [RW-1:0]       rst_cnt;
   logic [RW-1:0]       rst_inc;
   logic [NUM_PROJ-1:0] target_onehot;

   logic                connected;
   logic [IDX_W-1:0]    sel_idx;
   logic [IO_W-1:0]     mux_io_out;
   logic [IO_W-1:0]     mux_io_oeb;
   logic [LA_W-1:0]     mux_la_out;

   mux_stable_detect #(
      .NUM_PROJ      (NUM_PROJ),
      .STABLE_CYCLES (STABLE_CYCLES),
      .SEL_W         (SEL_W)
   ) u_stable_detect (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .active    (active_i),
      .target    (acc_target),
      .accept    (accept),
      .multi_hot (multi_hot)
   );

   // An accepted value only matters when it names a different design than the one being switched to.
   assign new_sel = accept && (acc_target != cur_target);

   assign guard_inc = (guard_cnt == GW'(GUARD_CYCLES)) ? guard_cnt : guard_cnt + GW'(1);
   assign rst_inc   = (rst_cnt == RW'(RST_CYCLES)) ? rst_cnt : rst_cnt + RW'(1);

   // One-hot form of the design the sequence is heading for; empty when the target is NONE.
   always_comb begin
      target_onehot = '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         if (cur_target == SEL_W'(i)) begin
            target_onehot[i] = 1'b1;
         end
      end
   end

   // Switch sequencer: drain with pads isolated, hold the new design in reset, then connect it.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state      <= IDLE;
         cur_target <= SEL_NONE;
         guard_cnt  <= '0;
         rst_cnt    <= '0;
         sel_o      <= SEL_NONE;
         busy_o     <= 1'b0;
         err_o      <= 1'b0;
         proj_rst_n <= '0;
      end else begin
         if (accept && multi_hot) begin
            err_o <= 1'b1;
         end
         if (new_sel) begin
            cur_target <= acc_target;
         end
         case (state)
            IDLE: begin
               if (new_sel && (acc_target != SEL_NONE)) begin
                  state     <= DRAIN;
                  guard_cnt <= '0;
                  busy_o    <= 1'b1;
               end
            end
            DRAIN: begin
               if (new_sel) begin
                  guard_cnt <= '0;
               end else if (guard_inc == GW'(GUARD_CYCLES)) begin
                  guard_cnt <= guard_inc;
                  if (cur_target == SEL_NONE) begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     state   <= RESET;
                     rst_cnt <= '0;
                  end
               end else begin
                  guard_cnt <= guard_inc;
               end
            end
            RESET: begin
               if (new_sel) begin
                  state     <= DRAIN;
                  guard_cnt <= '0;
               end else if (rst_inc == RW'(RST_CYCLES)) begin
                  rst_cnt    <= rst_inc;
                  state      <= RUN;
                  busy_o     <= 1'b0;
                  sel_o      <= cur_target;
                  proj_rst_n <= target_onehot;
               end else begin
                  rst_cnt <= rst_inc;
               end
            end
            RUN: begin
               if (new_sel) begin
                  state      <= DRAIN;
                  guard_cnt  <= '0;
                  busy_o     <= 1'b1;
                  sel_o      <= SEL_NONE;
                  proj_rst_n <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PROJ_CLK_GATE_EN
   // Clock only the design that is being reset or is running.
   always_comb begin
      proj_clk_en = '0;
      if ((state == RESET) || (state == RUN)) begin
         proj_clk_en = target_onehot;
      end
   end
`else
   assign proj_clk_en = '1;
`endif

   assign connected = !sel_o[SEL_W-1];
   assign sel_idx   = sel_o[IDX_W-1:0];

   // Route the connected design to the pads and LA; everyone else sees zeros and a disabled LA.
   always_comb begin
      mux_io_out   = '0;
      mux_io_oeb   = '1;
      mux_la_out   = '0;
      proj_io_in   = '0;
      proj_la_in   = '0;
      proj_la_oenb = '1;
      for (int i = 0; i < NUM_PROJ; i++) begin
         if (connected && (sel_idx == IDX_W'(i))) begin
            mux_io_out                   = proj_io_out[i*IO_W +: IO_W];
            mux_io_oeb                   = proj_io_oeb[i*IO_W +: IO_W];
            mux_la_out                   = proj_la_out[i*LA_W +: LA_W];
            proj_io_in[i*IO_W +: IO_W]   = io_in;
            proj_la_in[i*LA_W +: LA_W]   = la_data_in;
            proj_la_oenb[i*LA_W +: LA_W] = la_oenb;
         end
      end
   end

   // Register the pad and LA outputs so the pads see clean edges one cycle after the mux.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         io_out      <= '0;
         io_oeb      <= '1;
         la_data_out <= '0;
      end else begin
         io_out      <= mux_io_out;
         io_oeb      <= mux_io_oeb;
         la_data_out <= mux_la_out;
      end
   end

endmodule

// File: tb/tb_multi_project_io_mux.sv
// Directed bench for multi_project_io_mux with a time-ordered scoreboard:
// each stimulus step queues the outputs it should produce N cycles later.
// Honours PROJ_CLK_GATE_EN for the clock-enable expectations.
module tb_multi_project_io_mux;

   localparam int NP   = 4;
   localparam int IO_W = 38;
   localparam int LA_W = 32;

   localparam int K_SEL    = 0;
   localparam int K_BUSY   = 1;
   localparam int K_ERR    = 2;
   localparam int K_PRST   = 3;
   localparam int K_CLKEN  = 4;
   localparam int K_IOOUT  = 5;
   localparam int K_IOOEB  = 6;
   localparam int K_LAOUT  = 7;
   localparam int K_PIOIN  = 8;
   localparam int K_PLAIN  = 9;
   localparam int K_PLAOEN = 10;

   localparam logic [63:0] IO_ONES  = (64'd1 << IO_W) - 64'd1;
   localparam logic [63:0] LA_ONES  = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] SEL_NONE = 64'd4;

   logic                 clk;
   logic                 wb_rst_ni;
   logic [NP-1:0]        active_i;
   logic [IO_W-1:0]      io_in;
   logic [IO_W-1:0]      io_out;
   logic [IO_W-1:0]      io_oeb;
   logic [LA_W-1:0]      la_data_in;
   logic [LA_W-1:0]      la_oenb;
   logic [LA_W-1:0]      la_data_out;
   logic [NP*IO_W-1:0]   proj_io_in;
   logic [NP*IO_W-1:0]   proj_io_out;
   logic [NP*IO_W-1:0]   proj_io_oeb;
   logic [NP*LA_W-1:0]   proj_la_in;
   logic [NP*LA_W-1:0]   proj_la_oenb;
   logic [NP*LA_W-1:0]   proj_la_out;
   logic [NP-1:0]        proj_rst_n;
   logic [NP-1:0]        proj_clk_en;
   logic [2:0]           sel_o;
   logic                 busy_o;
   logic                 err_o;

   logic [IO_W-1:0]      io_pat  [NP];
   logic [IO_W-1:0]      oeb_pat [NP];
   logic [LA_W-1:0]      la_pat  [NP];

   typedef struct {
      int          due;
      string       tag;
      int          kind;
      int          idx;
      logic [63:0] value;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   errors;

   multi_project_io_mux #(
      .NUM_PROJ      (NP),
      .IO_W          (IO_W),
      .LA_W          (LA_W),
      .STABLE_CYCLES (4),
      .GUARD_CYCLES  (16),
      .RST_CYCLES    (8)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (wb_rst_ni),
      .active_i     (active_i),
      .io_in        (io_in),
      .io_out       (io_out),
      .io_oeb       (io_oeb),
      .la_data_in   (la_data_in),
      .la_oenb      (la_oenb),
      .la_data_out  (la_data_out),
      .proj_io_in   (proj_io_in),
      .proj_io_out  (proj_io_out),
      .proj_io_oeb  (proj_io_oeb),
      .proj_la_in   (proj_la_in),
      .proj_la_oenb (proj_la_oenb),
      .proj_la_out  (proj_la_out),
      .proj_rst_n   (proj_rst_n),
      .proj_clk_en  (proj_clk_en),
      .sel_o        (sel_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock enables follow the design in RESET/RUN only when gating is built in.
   function automatic logic [63:0] exp_clk_en(input logic [3:0] gated);
`ifdef PROJ_CLK_GATE_EN
      return 64'(gated);
`else
      return 64'(gated | 4'hF);
`endif
   endfunction

   function automatic logic [63:0] observe(input int kind, input int idx);
      logic [63:0] v;
      v = '0;
      case (kind)
         K_SEL:    v = 64'(sel_o);
         K_BUSY:   v = 64'(busy_o);
         K_ERR:    v = 64'(err_o);
         K_PRST:   v = 64'(proj_rst_n);
         K_CLKEN:  v = 64'(proj_clk_en);
         K_IOOUT:  v = 64'(io_out);
         K_IOOEB:  v = 64'(io_oeb);
         K_LAOUT:  v = 64'(la_data_out);
         K_PIOIN:  v = 64'(proj_io_in[idx*IO_W +: IO_W]);
         K_PLAIN:  v = 64'(proj_la_in[idx*LA_W +: LA_W]);
         K_PLAOEN: v = 64'(proj_la_oenb[idx*LA_W +: LA_W]);
         default:  v = '1;
      endcase
      return v;
   endfunction

   task automatic pushExpect(input int delay, input string tag, input int kind,
                             input int idx, input logic [63:0] value);
      exp_t e;
      int   pos;
      e.due   = cyc + delay;
      e.tag   = tag;
      e.kind  = kind;
      e.idx   = idx;
      e.value = value;
      pos = sb.size();
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due > e.due) begin
            pos = i;
         end
      end
      sb.insert(pos, e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [63:0] obs;
      obs = observe(e.kind, e.idx);
      checks++;
      assert (obs === e.value) else begin
         errors++;
         $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", e.tag, cyc, obs, e.value);
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic [NP-1:0] act);
      wb_rst_ni = rst_n;
      active_i  = act;
   endtask

   task automatic runCycles(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         while ((sb.size() > 0) && (sb[0].due <= cyc)) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   endtask

   // Queue the outputs expected once design d is fully connected (d = index, rel = RUN entry delay).
   task automatic expectConnected(input int rel, input int d, input string tag);
      pushExpect(rel - 1, {tag, " sel before run"}, K_SEL, 0, SEL_NONE);
      pushExpect(rel - 1, {tag, " busy before run"}, K_BUSY, 0, 64'd1);
      pushExpect(rel - 1, {tag, " rst held"}, K_PRST, 0, 64'd0);
      pushExpect(rel, {tag, " sel"}, K_SEL, 0, 64'(d));
      pushExpect(rel, {tag, " busy done"}, K_BUSY, 0, 64'd0);
      pushExpect(rel, {tag, " rst released"}, K_PRST, 0, 64'd1 << d);
      pushExpect(rel, {tag, " clk_en run"}, K_CLKEN, 0, exp_clk_en(4'(1 << d)));
      pushExpect(rel, {tag, " io_out lag"}, K_IOOUT, 0, 64'd0);
      pushExpect(rel + 1, {tag, " io_out"}, K_IOOUT, 0, 64'(io_pat[d]));
      pushExpect(rel + 1, {tag, " io_oeb"}, K_IOOEB, 0, 64'(oeb_pat[d]));
      pushExpect(rel + 1, {tag, " la_out"}, K_LAOUT, 0, 64'(la_pat[d]));
      pushExpect(rel + 1, {tag, " proj_io_in sel"}, K_PIOIN, d, 64'(io_in));
      pushExpect(rel + 1, {tag, " proj_la_in sel"}, K_PLAIN, d, 64'(la_data_in));
      pushExpect(rel + 1, {tag, " proj_la_oenb sel"}, K_PLAOEN, d, 64'(la_oenb));
      pushExpect(rel + 1, {tag, " proj_io_in other"}, K_PIOIN, (d + 1) % NP, 64'd0);
      pushExpect(rel + 1, {tag, " proj_la_oenb other"}, K_PLAOEN, (d + 2) % NP, LA_ONES);
   endtask

   initial begin
      cyc    = 0;
      checks = 0;
      errors = 0;
      io_in      = IO_W'({$urandom(), $urandom()});
      la_data_in = $urandom();
      la_oenb    = $urandom();
      for (int i = 0; i < NP; i++) begin
         io_pat[i]  = IO_W'({$urandom(), $urandom()});
         oeb_pat[i] = IO_W'({$urandom(), $urandom()});
         la_pat[i]  = $urandom();
         proj_io_out[i*IO_W +: IO_W] = io_pat[i];
         proj_io_oeb[i*IO_W +: IO_W] = oeb_pat[i];
         proj_la_out[i*LA_W +: LA_W] = la_pat[i];
      end

      $display("[TB] reset values");
      applyStimulus(1'b0, 4'b0000);
      pushExpect(1, "rst sel", K_SEL, 0, SEL_NONE);
      pushExpect(1, "rst busy", K_BUSY, 0, 64'd0);
      pushExpect(1, "rst err", K_ERR, 0, 64'd0);
      pushExpect(1, "rst io_out", K_IOOUT, 0, 64'd0);
      pushExpect(1, "rst io_oeb", K_IOOEB, 0, IO_ONES);
      pushExpect(1, "rst la_out", K_LAOUT, 0, 64'd0);
      pushExpect(1, "rst proj_rst_n", K_PRST, 0, 64'd0);
      pushExpect(1, "rst clk_en", K_CLKEN, 0, exp_clk_en(4'b0000));
      pushExpect(1, "rst proj_la_oenb", K_PLAOEN, 1, LA_ONES);
      pushExpect(1, "rst proj_io_in", K_PIOIN, 1, 64'd0);
      runCycles(2);

      $display("[TB] select design 1 from idle");
      applyStimulus(1'b1, 4'b0010);
      pushExpect(3, "A busy pre", K_BUSY, 0, 64'd0);
      pushExpect(4, "A busy rise", K_BUSY, 0, 64'd1);
      pushExpect(4, "A oeb drain", K_IOOEB, 0, IO_ONES);
      pushExpect(19, "A clk_en drain", K_CLKEN, 0, exp_clk_en(4'b0000));
      pushExpect(20, "A clk_en reset", K_CLKEN, 0, exp_clk_en(4'b0010));
      expectConnected(28, 1, "A");
      runCycles(30);

      $display("[TB] switch design 1 -> 2");
      applyStimulus(1'b1, 4'b0100);
      pushExpect(3, "B sel still 1", K_SEL, 0, 64'd1);
      pushExpect(3, "B rst still 1", K_PRST, 0, 64'd2);
      pushExpect(4, "B sel none", K_SEL, 0, SEL_NONE);
      pushExpect(4, "B busy", K_BUSY, 0, 64'd1);
      pushExpect(4, "B rst drain", K_PRST, 0, 64'd0);
      pushExpect(5, "B oeb drain start", K_IOOEB, 0, IO_ONES);
      pushExpect(5, "B io_out drain", K_IOOUT, 0, 64'd0);
      pushExpect(20, "B rst in reset", K_PRST, 0, 64'd0);
      pushExpect(20, "B clk_en reset", K_CLKEN, 0, exp_clk_en(4'b0100));
      pushExpect(28, "B oeb drain end", K_IOOEB, 0, IO_ONES);
      expectConnected(28, 2, "B");
      runCycles(30);

      $display("[TB] deselect to idle");
      applyStimulus(1'b1, 4'b0000);
      pushExpect(4, "C busy drain", K_BUSY, 0, 64'd1);
      pushExpect(19, "C busy late", K_BUSY, 0, 64'd1);
      pushExpect(20, "C busy idle", K_BUSY, 0, 64'd0);
      pushExpect(20, "C sel none", K_SEL, 0, SEL_NONE);
      pushExpect(20, "C rst none", K_PRST, 0, 64'd0);
      runCycles(22);

      $display("[TB] three-cycle glitch");
      applyStimulus(1'b1, 4'b0001);
      pushExpect(1, "G busy 1", K_BUSY, 0, 64'd0);
      pushExpect(3, "G busy 3", K_BUSY, 0, 64'd0);
      runCycles(3);
      applyStimulus(1'b1, 4'b0000);
      pushExpect(1, "G busy after", K_BUSY, 0, 64'd0);
      pushExpect(5, "G busy settled", K_BUSY, 0, 64'd0);
      pushExpect(6, "G sel", K_SEL, 0, SEL_NONE);
      pushExpect(6, "G oeb", K_IOOEB, 0, IO_ONES);
      runCycles(8);

      $display("[TB] multi-hot select");
      applyStimulus(1'b1, 4'b0011);
      pushExpect(3, "D err pre", K_ERR, 0, 64'd0);
      pushExpect(4, "D err set", K_ERR, 0, 64'd1);
      pushExpect(4, "D busy", K_BUSY, 0, 64'd0);
      pushExpect(6, "D sel", K_SEL, 0, SEL_NONE);
      pushExpect(6, "D oeb", K_IOOEB, 0, IO_ONES);
      runCycles(8);
      applyStimulus(1'b1, 4'b0001);
      pushExpect(4, "D2 busy", K_BUSY, 0, 64'd1);
      pushExpect(28, "D2 err sticky", K_ERR, 0, 64'd1);
      expectConnected(28, 0, "D2");
      runCycles(30);

      $display("[TB] reset during RESET of design 3");
      applyStimulus(1'b1, 4'b1000);
      pushExpect(22, "E busy", K_BUSY, 0, 64'd1);
      pushExpect(22, "E rst held", K_PRST, 0, 64'd0);
      pushExpect(22, "E clk_en reset", K_CLKEN, 0, exp_clk_en(4'b1000));
      runCycles(22);
      applyStimulus(1'b0, 4'b1000);
      pushExpect(1, "E rst sel", K_SEL, 0, SEL_NONE);
      pushExpect(1, "E rst busy", K_BUSY, 0, 64'd0);
      pushExpect(1, "E rst err", K_ERR, 0, 64'd0);
      pushExpect(1, "E rst proj_rst_n", K_PRST, 0, 64'd0);
      pushExpect(1, "E rst clk_en", K_CLKEN, 0, exp_clk_en(4'b0000));
      pushExpect(1, "E rst io_oeb", K_IOOEB, 0, IO_ONES);
      runCycles(1);
      applyStimulus(1'b1, 4'b1000);
      pushExpect(3, "E2 busy pre", K_BUSY, 0, 64'd0);
      pushExpect(4, "E2 busy rise", K_BUSY, 0, 64'd1);
      pushExpect(28, "E2 err clear", K_ERR, 0, 64'd0);
      expectConnected(28, 3, "E2");
      runCycles(30);

      $display("[TB] reselect during RESET");
      applyStimulus(1'b1, 4'b0001);
      pushExpect(20, "F clk_en reset0", K_CLKEN, 0, exp_clk_en(4'b0001));
      runCycles(22);
      applyStimulus(1'b1, 4'b0010);
      pushExpect(3, "F busy in reset", K_BUSY, 0, 64'd1);
      pushExpect(4, "F back to drain", K_CLKEN, 0, exp_clk_en(4'b0000));
      pushExpect(6, "F no run 0", K_SEL, 0, SEL_NONE);
      pushExpect(19, "F guard full", K_CLKEN, 0, exp_clk_en(4'b0000));
      pushExpect(20, "F clk_en reset1", K_CLKEN, 0, exp_clk_en(4'b0010));
      expectConnected(28, 1, "F");
      runCycles(30);

      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s never reached (due %0d, now %0d)", e.tag, e.due, cyc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
